// File: rtl/conv_pkg.sv
// Shared types, constants and operand validation for the sequential BCD<->binary converter.
package conv_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned SR_W   = 2 * DATA_W;
  localparam int unsigned N_ITER = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic DIR_B2BCD = 1'b0;
  localparam logic DIR_BCD2B = 1'b1;

  localparam logic [DATA_W-1:0] MAX_BIN       = 8'd99;
  localparam logic [NIB_W-1:0]  BCD_DIGIT_MAX = 4'd9;
  localparam logic [NIB_W-1:0]  ADD_THRESH    = 4'd5;
  localparam logic [NIB_W-1:0]  SUB_THRESH    = 4'd8;
  localparam logic [NIB_W-1:0]  ADJ_VAL       = 4'd3;

  // Shift register shared by both directions: BCD digits on top, binary below.
  typedef struct packed {
    logic [DATA_W-1:0] bcd;
    logic [DATA_W-1:0] bin;
  } sr_t;

  function automatic logic operand_invalid(input logic dir, input logic [DATA_W-1:0] data);
    if (dir == DIR_B2BCD) return (data > MAX_BIN);
    return (data[7:4] > BCD_DIGIT_MAX) || (data[3:0] > BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/conv_bcd_bin_seq_if.sv
// Request/result handshake between the Pico port glue and the converter.
interface conv_bcd_bin_seq_if;
  import conv_pkg::*;

  logic              req;
  logic              dir;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic              err;

  modport master (output req, dir, data_in, input busy, done, data_out, err);
  modport slave  (input req, dir, data_in, output busy, done, data_out, err);
endinterface

// File: rtl/bcd_nibble_adj.sv
// Per-digit correction: +3 when >=5 (double dabble) or -3 when >=8 (reverse double dabble).
module bcd_nibble_adj
  import conv_pkg::*;
(
  input  logic             mode_i,
  input  logic [NIB_W-1:0] nib_i,
  output logic [NIB_W-1:0] nib_o
);

  always_comb begin
    nib_o = nib_i;
    if (mode_i == DIR_B2BCD) begin
      if (nib_i >= ADD_THRESH) nib_o = nib_i + ADJ_VAL;
    end else begin
      if (nib_i >= SUB_THRESH) nib_o = nib_i - ADJ_VAL;
    end
  end

endmodule

// File: rtl/conv_bcd_bin_seq.sv
// Iterative BCD<->binary converter: one shift/adjust step per cycle, fixed 8-cycle latency.
module conv_bcd_bin_seq
  import conv_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  conv_bcd_bin_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              operr_q, operr_d;
  sr_t               sr_q, sr_d, sr_iter;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              err_q, err_d;

  logic              accept;
  logic              last_iter;
  logic [SR_W-1:0]   sr_shr;
  logic [NIB_W-1:0]  nib_hi_in, nib_lo_in, nib_hi_adj, nib_lo_adj;

  assign accept    = (state_q == IDLE) && bus.req;
  assign last_iter = (state_q == CONV) && (cnt_q == CNT_W'(N_ITER - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req) state_d = CONV;
      CONV:    if (cnt_q == CNT_W'(N_ITER - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the state register only
  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
  end

  assign bus.data_out = data_out_q;
  assign bus.err      = err_q;

  // Forward direction adjusts before the left shift; reverse adjusts after the right shift.
  assign sr_shr    = sr_q >> 1;
  assign nib_hi_in = (dir_q == DIR_BCD2B) ? sr_shr[15:12] : sr_q.bcd[7:4];
  assign nib_lo_in = (dir_q == DIR_BCD2B) ? sr_shr[11:8]  : sr_q.bcd[3:0];

  bcd_nibble_adj u_adj_hi (
    .mode_i (dir_q),
    .nib_i  (nib_hi_in),
    .nib_o  (nib_hi_adj)
  );

  bcd_nibble_adj u_adj_lo (
    .mode_i (dir_q),
    .nib_i  (nib_lo_in),
    .nib_o  (nib_lo_adj)
  );

  always_comb begin
    if (dir_q == DIR_BCD2B) sr_iter = {nib_hi_adj, nib_lo_adj, sr_shr[7:0]};
    else                    sr_iter = {nib_hi_adj, nib_lo_adj, sr_q.bin} << 1;
  end

  // Datapath next-state: capture on acceptance, iterate in CONV, publish on the last step
  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    operr_d    = operr_q;
    sr_d       = sr_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    if (accept) begin
      dir_d   = bus.dir;
      operr_d = operand_invalid(bus.dir, bus.data_in);
      cnt_d   = '0;
      sr_d    = (bus.dir == DIR_BCD2B) ? {bus.data_in, DATA_W'(0)} : {DATA_W'(0), bus.data_in};
    end else if (state_q == CONV) begin
      sr_d  = sr_iter;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        cnt_d      = '0;
        err_d      = operr_q;
        data_out_d = operr_q ? DATA_W'(0)
                   : ((dir_q == DIR_BCD2B) ? sr_iter.bin : sr_iter.bcd);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      dir_q      <= DIR_B2BCD;
      operr_q    <= 1'b0;
      sr_q       <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      operr_q    <= operr_d;
      sr_q       <= sr_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_conv_bcd_bin_seq.sv
// Scoreboard bench for conv_bcd_bin_seq: a cycle model predicts busy/done and converted results.
module tb_conv_bcd_bin_seq;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk;
  logic reset_n;
  logic chk_en;

  int n_checks;
  int n_fail;
  int mdl_left;
  int n_pred;
  int n_done;

  logic [7:0] mdl_dout;
  logic       mdl_err;
  exp_t       sb[$];

  conv_bcd_bin_seq_if bus ();

  conv_bcd_bin_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference conversion by decimal arithmetic
  function automatic exp_t model_conv(input logic d, input logic [7:0] v);
    exp_t e;
    int   iv;
    int   hi;
    int   lo;
    iv = int'(v);
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    e.data = 8'h00;
    e.err  = 1'b1;
    if (d == 1'b0) begin
      if (iv <= 99) begin
        e.data = 8'(((iv / 10) * 16) + (iv % 10));
        e.err  = 1'b0;
      end
    end else begin
      if (hi <= 9 && lo <= 9) begin
        e.data = 8'((hi * 10) + lo);
        e.err  = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // Cycle model: acceptance only when idle, 8 CONV cycles plus one DONE cycle
  always @(posedge clk or negedge reset_n) begin
    exp_t e;
    if (!reset_n) begin
      mdl_left = 0;
      mdl_dout = 8'h00;
      mdl_err  = 1'b0;
      sb.delete();
    end else if (mdl_left == 0) begin
      if (bus.req === 1'b1) begin
        sb.push_back(model_conv(bus.dir, bus.data_in));
        mdl_left = 9;
      end
    end else begin
      mdl_left--;
      if (mdl_left == 1) begin
        e        = sb.pop_front();
        mdl_dout = e.data;
        mdl_err  = e.err;
        n_pred++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("busy", 32'(bus.busy), 32'(mdl_left != 0));
      check_val("done", 32'(bus.done), 32'(mdl_left == 1));
      check_val("data_out", 32'(bus.data_out), 32'(mdl_dout));
      check_val("err", 32'(bus.err), 32'(mdl_err));
      if (bus.done === 1'b1) n_done++;
    end
  end

  task automatic do_conv(input logic d, input logic [7:0] v);
    bus.req     = 1'b1;
    bus.dir     = d;
    bus.data_in = v;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'(0));
    check_val({tag, "_done"}, 32'(bus.done), 32'(0));
    check_val({tag, "_data_out"}, 32'(bus.data_out), 32'(0));
    check_val({tag, "_err"}, 32'(bus.err), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    n_pred      = 0;
    n_done      = 0;
    chk_en      = 1'b0;
    reset_n     = 1'b0;
    bus.req     = 1'b0;
    bus.dir     = 1'b0;
    bus.data_in = 8'h00;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");
    chk_en = 1'b1;

    // Directed conversions, valid and invalid
    do_conv(1'b0, 8'h3B);
    do_conv(1'b0, 8'h00);
    do_conv(1'b0, 8'h63);
    do_conv(1'b1, 8'h59);
    do_conv(1'b1, 8'h10);
    do_conv(1'b1, 8'h99);
    do_conv(1'b0, 8'h64);
    do_conv(1'b1, 8'h1A);
    do_conv(1'b1, 8'hA0);
    do_conv(1'b0, 8'hFF);

    // req held with changing operands during busy must be ignored
    bus.req     = 1'b1;
    bus.dir     = 1'b0;
    bus.data_in = 8'h2A;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      bus.dir     = 1'(i % 2);
      bus.data_in = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    bus.req = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion aborts it
    do_conv(1'b1, 8'h77);
    bus.req     = 1'b1;
    bus.dir     = 1'b0;
    bus.data_in = 8'h45;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (4) @(negedge clk);
    chk_en  = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    repeat (12) @(negedge clk);

    // Continuous request: back-to-back conversions, one done each
    bus.req = 1'b1;
    for (int i = 0; i < 45; i++) begin
      bus.dir     = 1'($urandom_range(0, 1));
      bus.data_in = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    bus.req = 1'b0;
    repeat (12) @(negedge clk);

    // Round trip over all two-digit values
    for (int v = 0; v <= 99; v++) begin
      do_conv(1'b0, 8'(v));
      do_conv(1'b1, to_bcd(v));
    end

    // All BCD input codes, errors on any nibble above 9
    for (int v = 0; v < 256; v++) begin
      do_conv(1'b1, 8'(v));
    end

    repeat (4) @(negedge clk);
    check_val("done_count", 32'(n_done), 32'(n_pred));
    check_val("sb_drain", 32'(sb.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
